// File: rtl/simon64_96_pkg.sv
// Shared constants and types for the SIMON64/96 key schedule.
package simon64_96_pkg;

    localparam int WORD_W     = 32;
    localparam int KEY_WORDS  = 3;
    localparam int NUM_ROUNDS = 42;
    localparam int Z_LEN      = 62;

    localparam logic [WORD_W-1:0] C_CONST = 32'hFFFF_FFFC;

    // z2 sequence written as published, leftmost digit first.
    localparam logic [Z_LEN-1:0] Z2_DIGITS =
        62'b10101111011100000011010010011000101000010001111110010110110011;

    // Reverse the digit string so that Z2[i] is the i-th digit of the sequence.
    function automatic logic [Z_LEN-1:0] rev_z(input logic [Z_LEN-1:0] v);
        logic [Z_LEN-1:0] r;
        for (int i = 0; i < Z_LEN; i++) begin
            r[i] = v[Z_LEN-1-i];
        end
        return r;
    endfunction

    localparam logic [Z_LEN-1:0] Z2 = rev_z(Z2_DIGITS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/simon64_96_key_step.sv
// One SIMON64/96 key-expansion step: new window word from w0, w2 and the z bit.
module simon64_96_key_step
    import simon64_96_pkg::*;
(
    input  logic [WORD_W-1:0] w0_i,
    input  logic [WORD_W-1:0] w2_i,
    input  logic              zbit_i,
    output logic [WORD_W-1:0] knew_o
);

    logic [WORD_W-1:0] ror3;
    logic [WORD_W-1:0] ror4;

    assign ror3 = {w2_i[2:0], w2_i[WORD_W-1:3]};
    assign ror4 = {w2_i[3:0], w2_i[WORD_W-1:4]};

    // The constant folds the bitwise inversion of w0 and the low "3" together.
    assign knew_o = C_CONST ^ {{(WORD_W-1){1'b0}}, zbit_i} ^ w0_i ^ ror3 ^ ror4;

endmodule

// File: rtl/simon64_96_key_schedule.sv
// SIMON64/96 key schedule: accepts a 96-bit key and streams 42 round subkeys
// with a valid/ready handshake, one per cycle at full throughput.
module simon64_96_key_schedule #(
    parameter int NUM_ROUNDS = 42,
    parameter int WORD_W     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3*WORD_W-1:0] key_in,
    input  logic                key_valid,
    output logic                key_ready,
    output logic [WORD_W-1:0]   subkey,
    output logic [5:0]          round_idx,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic                last,
    output logic                busy
);

    import simon64_96_pkg::*;

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);
    localparam logic [5:0] ZI_MAX   = 6'(Z_LEN - 1);

    state_e            state_q;
    logic [WORD_W-1:0] w0_q;
    logic [WORD_W-1:0] w1_q;
    logic [WORD_W-1:0] w2_q;
    logic [5:0]        idx_q;
    logic [5:0]        zi_q;

    logic [WORD_W-1:0] knew_d;
    logic [5:0]        idx_d;
    logic [5:0]        zi_d;
    logic              key_acc;
    logic              sk_hs;
    logic              is_last;

    assign key_acc = (state_q == ST_IDLE) && key_valid;
    assign sk_hs   = (state_q == ST_RUN) && subkey_ready;
    assign is_last = (state_q == ST_RUN) && (idx_q == LAST_IDX);
    assign idx_d   = idx_q + 6'd1;
    // z index wraps over the 62-entry sequence even though 42 rounds never reach it.
    assign zi_d    = (zi_q == ZI_MAX) ? 6'd0 : zi_q + 6'd1;

    simon64_96_key_step u_step (
        .w0_i   (w0_q),
        .w2_i   (w2_q),
        .zbit_i (Z2[zi_q]),
        .knew_o (knew_d)
    );

    // FSM plus window and counters: load on key accept, slide on each subkey handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            idx_q   <= '0;
            zi_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_acc) begin
                        w0_q    <= key_in[WORD_W-1:0];
                        w1_q    <= key_in[2*WORD_W-1:WORD_W];
                        w2_q    <= key_in[3*WORD_W-1:2*WORD_W];
                        idx_q   <= '0;
                        zi_q    <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sk_hs && is_last) begin
                        state_q <= ST_IDLE;
                    end else if (sk_hs) begin
                        w0_q  <= w1_q;
                        w1_q  <= w2_q;
                        w2_q  <= knew_d;
                        idx_q <= idx_d;
                        zi_q  <= zi_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign key_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_RUN);
    assign subkey_valid = (state_q == ST_RUN);
    assign subkey       = w0_q;
    assign round_idx    = idx_q;
    assign last         = is_last;

endmodule

// File: tb/tb_simon64_96_key_schedule.sv
// Bench for the SIMON64/96 key schedule: known vectors, software model
// comparison, stalls, ignored keys, mid-run reset and back-to-back keys.
module tb_simon64_96_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] key_in;
    logic        key_valid;
    logic        key_ready;
    logic [31:0] subkey;
    logic [5:0]  round_idx;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] got    [0:41];
    logic [31:0] exp_ks [0:41];

    typedef struct {
        logic [95:0] key;
        logic [31:0] e0, e1, e2, e3;
    } vec_t;
    vec_t tv [4];

    simon64_96_key_schedule dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .subkey       (subkey),
        .round_idx    (round_idx),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .last         (last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] v, input int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Reference SIMON key expansion for m = 3, written as in the cipher definition.
    task automatic model_ks(input logic [95:0] key);
        logic [31:0] k [0:41];
        logic [61:0] zdig;
        logic [31:0] tmp;
        zdig = 62'b10101111011100000011010010011000101000010001111110010110110011;
        k[0] = key[31:0];
        k[1] = key[63:32];
        k[2] = key[95:64];
        for (int i = 0; i < 39; i++) begin
            tmp = ror(k[i+2], 3);
            tmp = tmp ^ ror(tmp, 1);
            k[i+3] = ~k[i] ^ tmp ^ {31'd0, zdig[61 - (i % 62)]} ^ 32'd3;
        end
        for (int i = 0; i < 42; i++) exp_ks[i] = k[i];
    endtask

    task automatic encrypt(input logic [63:0] pt, output logic [63:0] ct);
        logic [31:0] x, y, t;
        x = pt[63:32];
        y = pt[31:0];
        for (int r = 0; r < 42; r++) begin
            t = x;
            x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ got[r];
            y = t;
        end
        ct = {x, y};
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 42; i++) begin
            chk($sformatf("%s_subkey%0d", tag, i), got[i], exp_ks[i]);
        end
    endtask

    // Called at posedge+1 in IDLE; the key is accepted at the next edge.
    task automatic send_key(input logic [95:0] k);
        int t = 0;
        key_in    = k;
        key_valid = 1'b1;
        while (!key_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) chk("send_key_timeout", t, 0);
        @(posedge clk); #1;
        key_valid = 1'b0;
        chk("latency_valid", subkey_valid, 1);
        chk("first_subkey", subkey, k[31:0]);
        chk("first_idx", round_idx, 0);
        chk("busy_run", busy, 1);
        chk("key_ready_run", key_ready, 0);
    endtask

    task automatic collect(input int stall_pct, input bit do_inject, input logic [95:0] inj_key,
                           input bit hold_valid, input logic [95:0] next_key);
        int n = 0;
        int cyc = 0;
        bit stalled = 0;
        bit injected = 0;
        bit rdy;
        logic [31:0] hk;
        logic [5:0]  hi;
        while (n < 42 && cyc < 2000) begin
            chk("valid_in_run", subkey_valid, 1);
            if (stalled) begin
                chk("stall_subkey", subkey, hk);
                chk("stall_idx", round_idx, hi);
            end
            rdy          = ($urandom_range(99) >= stall_pct);
            subkey_ready = rdy;
            key_valid    = hold_valid;
            if (do_inject && !injected && round_idx == 6'd10) begin
                key_in    = inj_key;
                key_valid = 1'b1;
                injected  = 1;
                chk("key_ready_low_inject", key_ready, 0);
            end
            if (rdy) begin
                got[n] = subkey;
                chk("round_idx", round_idx, n);
                chk("last_flag", last, (n == 41));
                if (hold_valid && n == 41) key_in = next_key;
                n++;
                stalled = 0;
            end else begin
                stalled = 1;
                hk = subkey;
                hi = round_idx;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (n < 42) chk("collect_timeout", n, 42);
        if (stall_pct == 0) chk("throughput", cyc, 42);
        if (do_inject) chk("inject_done", injected, 1);
    endtask

    task automatic post_done();
        chk("done_valid_low", subkey_valid, 0);
        chk("done_key_ready", key_ready, 1);
        chk("done_busy_low", busy, 0);
    endtask

    initial begin
        logic [95:0] ka, kb;
        logic [63:0] ct;
        int g;

        tv[0] = '{96'h13121110_0b0a0908_03020100, 32'h03020100, 32'h0b0a0908, 32'h13121110, 32'hFFAE9DCE};
        tv[1] = '{96'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFD};
        tv[2] = '{{96{1'b1}}, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002};
        tv[3] = '{96'hDEADBEEF_01234567_89ABCDEF, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF, 32'h706B5E21};

        rst_n        = 1'b0;
        key_in       = '0;
        key_valid    = 1'b0;
        subkey_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", subkey_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last", last, 0);
        chk("rst_idx", round_idx, 0);
        chk("rst_subkey", subkey, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_key_ready", key_ready, 1);
        chk("post_rst_valid", subkey_valid, 0);

        // Known vectors with full-rate consumer
        for (int t = 0; t < 4; t++) begin
            model_ks(tv[t].key);
            send_key(tv[t].key);
            collect(0, 0, '0, 0, '0);
            post_done();
            chk($sformatf("tv%0d_k0", t), got[0], tv[t].e0);
            chk($sformatf("tv%0d_k1", t), got[1], tv[t].e1);
            chk($sformatf("tv%0d_k2", t), got[2], tv[t].e2);
            chk($sformatf("tv%0d_k3", t), got[3], tv[t].e3);
            compare_all($sformatf("tv%0d", t));
            if (t == 0) begin
                encrypt(64'h6f7220676e696c63, ct);
                chk("encrypt_kat", ct, 64'h5ca2e27f111a8fc8);
            end
        end

        // Random keys with a 50% stalling consumer
        for (int r = 0; r < 3; r++) begin
            ka = {$urandom(), $urandom(), $urandom()};
            model_ks(ka);
            send_key(ka);
            collect(50, 0, '0, 0, '0);
            post_done();
            compare_all($sformatf("stall%0d", r));
        end

        // Key offered mid-run must be ignored
        ka = tv[0].key;
        kb = {$urandom(), $urandom(), $urandom()};
        model_ks(ka);
        send_key(ka);
        collect(0, 1, kb, 0, '0);
        post_done();
        compare_all("inject");

        // Asynchronous reset in the middle of a run
        ka = {$urandom(), $urandom(), $urandom()};
        send_key(ka);
        subkey_ready = 1'b1;
        g = 0;
        while (round_idx != 6'd20 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        chk("reached_idx20", round_idx, 20);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", subkey_valid, 0);
        chk("arst_subkey", subkey, 0);
        chk("arst_idx", round_idx, 0);
        chk("arst_last", last, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_key_ready", key_ready, 1);
        chk("arst_no_subkey", subkey_valid, 0);
        @(posedge clk); #1;
        chk("arst_still_idle", subkey_valid, 0);
        kb = {$urandom(), $urandom(), $urandom()};
        model_ks(kb);
        send_key(kb);
        collect(0, 0, '0, 0, '0);
        post_done();
        compare_all("after_rst");

        // Back-to-back keys with key_valid held high
        ka = {$urandom(), $urandom(), $urandom()};
        kb = {$urandom(), $urandom(), $urandom()};
        model_ks(ka);
        send_key(ka);
        collect(0, 0, '0, 1, kb);
        post_done();
        compare_all("b2b_a");
        @(posedge clk); #1;
        key_valid = 1'b0;
        chk("b2b_valid", subkey_valid, 1);
        chk("b2b_first", subkey, kb[31:0]);
        chk("b2b_idx", round_idx, 0);
        model_ks(kb);
        collect(0, 0, '0, 0, '0);
        post_done();
        compare_all("b2b_b");

        // Consumer ready while idle has no effect
        subkey_ready = 1'b1;
        key_valid    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_ready_valid", subkey_valid, 0);
            chk("idle_ready_busy", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
